serial_a_paralelo_idle_rx: RTL and testbench
============================================

# serial_a_paralelo_idle_rx

Receive-side counterpart of the lane serializer. It samples the serial lane one bit per `clk32f` cycle, MSB first, and hunts for the 8'hBC IDLE comma. Once it sees `BC_COUNT` consecutive byte-aligned BC characters it declares the lane active. From then on it delivers every received byte in parallel with a one-cycle valid strobe, and flags IDLE (BC) and 7C characters.

## Interface
- `BC_COUNT`, default 4: consecutive aligned BC bytes required to lock. Legal range 1..15.
- `clk32f` input 1: bit clock. Everything is registered on its rising edge.
- `reset` input 1: synchronous, active-low. Sampled on the rising edge of `clk32f`.
- `in` input 1: serial data, MSB first. One bit is sampled per `clk32f` edge.
- `out` output 8: last byte received while locked.
- `valid_out` output 1: one-cycle pulse when `out` is loaded with a new byte.
- `active` output 1: lane locked (alignment achieved).
- `idle_k` output 1: qualifies `out`; 1 when `out` == 8'hBC.
- `k7c` output 1: qualifies `out`; 1 when `out` == 8'h7C.

## Operation
- Shift register `shreg[7:0]` loads `{shreg[6:0], in}` every non-reset edge.
- `window` is the combinational value `{shreg[6:0], in}`, i.e. the byte that completes on the current edge.
- `bitcnt` is a 3-bit counter of bit position inside a byte. It wraps 7 -> 0.
- `bccnt` is a 4-bit counter of aligned BC bytes seen.
- States:
  - HUNT, the reset state.
    - Every edge, compare `window` with 8'hBC.
    - On a match: set `bitcnt` to 0 and `bccnt` to 1. Go to LOCKED with `active` set to 1 if `BC_COUNT` == 1; otherwise go to COUNT.
  - COUNT.
    - `bitcnt` increments each edge. A byte boundary is the edge where `bitcnt` == 7.
    - At a boundary with `window` == BC: increment `bccnt`. If the new value == `BC_COUNT`, go to LOCKED and set `active` to 1.
    - At a boundary with `window` != BC: set `bccnt` to 0 and go to HUNT.
    - No outputs change in COUNT.
  - LOCKED.
    - `bitcnt` keeps counting.
    - At every boundary: `out` <= `window`, `valid_out` <= 1, `idle_k` <= (`window` == BC), `k7c` <= (`window` == 7C).
    - On all other edges `valid_out` <= 0. `out`, `idle_k` and `k7c` hold their values.
    - LOCKED is left only by reset. Lock is not dropped on data content.
- Reset (`reset` == 0 at an edge):
  - Outputs: `out` = 0, `valid_out` = 0, `active` = 0, `idle_k` = 0, `k7c` = 0.
  - Internal: `shreg` = 0, `bitcnt` = 0, `bccnt` = 0, state = HUNT.
  - Reset applies mid-byte and in any state, and abandons any partial byte.
- Simultaneous events:
  - Reset has priority over every other update.
  - In COUNT, the boundary edge that reaches `BC_COUNT` does not also emit a byte. The first `valid_out` occurs 8 edges later.

## Timing
- The byte whose LSB is sampled at edge N appears on `out`, `valid_out`, `idle_k` and `k7c` immediately after edge N. Latency is 0 cycles beyond the last bit.
- `active` rises on the edge that samples the LSB of the `BC_COUNT`-th aligned BC.
- While LOCKED, `valid_out` pulses exactly every 8 cycles and is high for 1 cycle.
- `active` stays high and `valid_out` keeps its 8-cycle cadence indefinitely, until reset.
- After reset is released, the earliest possible lock is 8·`BC_COUNT` edges.
- A false BC match in HUNT can cost extra bytes before lock, but lock is still guaranteed on a continuous BC stream. BC is comma-safe: BC·BC contains no misaligned BC window.

## Test plan
- Reset hold: `reset` = 0 for 10 cycles with random `in` -> `out` = 0, `valid_out` = 0, `active` = 0, `idle_k` = 0, `k7c` = 0 on every cycle.
- Lock with offset: release reset, send 3 junk bits `101`, then BC×6 MSB first.
  - `active` rises at the edge sampling the LSB of the 4th BC (edge 35).
  - `valid_out` pulses at edges 43 and 51 with `out` = 8'hBC and `idle_k` = 1.
- Broken run: send BC×3, 8'h00, BC×4 -> `active` stays 0 through the 8'h00 byte and rises at the LSB of the 4th BC that follows it.
- Data after lock: lock, then send 7C, A5, BC -> three `valid_out` pulses 8 cycles apart.
  - 1st pulse: `out` = 7C, `k7c` = 1.
  - 2nd pulse: `out` = A5, `k7c` = 0, `idle_k` = 0.
  - 3rd pulse: `out` = BC, `idle_k` = 1.
- Reset mid-lock: while locked, drive `reset` = 0 for one edge at `bitcnt` = 4.
  - All outputs clear after that edge.
  - After resuming BC, relock requires 4 fresh aligned BC bytes.
- Parameter: `BC_COUNT` = 1, send one BC -> `active` rises at its LSB, and the first `valid_out` comes 8 edges later.

Source files
------------

// File: rtl/serial_a_paralelo_idle_rx_if.sv
// serial_a_paralelo_idle_rx_if: serial lane input plus the parallel byte outputs of the receiver
interface serial_a_paralelo_idle_rx_if;
  logic       in;
  logic [7:0] out;
  logic       valid_out;
  logic       active;
  logic       idle_k;
  logic       k7c;
  modport master (output in, input out, valid_out, active, idle_k, k7c);
  modport slave (input in, output out, valid_out, active, idle_k, k7c);
endinterface

// File: rtl/serial_a_paralelo_idle_rx.sv
// serial_a_paralelo_idle_rx: MSB-first deserializer that locks on BC_COUNT aligned 8'hBC commas
module serial_a_paralelo_idle_rx #(
  parameter int BC_COUNT = 4
) (
  input logic                        clk32f,
  input logic                        reset,
  serial_a_paralelo_idle_rx_if.slave lane
);
  typedef enum logic [1:0] {HUNT, COUNT, LOCKED} state_e;
  state_e     state_q, state_d;
  logic [7:0] shreg_q, shreg_d, out_q, out_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [3:0] bccnt_q, bccnt_d;
  logic       valid_q, valid_d, active_q, active_d, idle_q, idle_d, k7c_q, k7c_d;
  logic [7:0] window;
  logic       is_bc, boundary;
  assign window   = {shreg_q[6:0], lane.in};
  assign is_bc    = window == 8'hBC;
  assign boundary = bitcnt_q == 3'd7;
  always_ff @(posedge clk32f) begin
    if (!reset) begin
      state_q  <= HUNT;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      bccnt_q  <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      idle_q   <= 1'b0;
      k7c_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      bccnt_q  <= bccnt_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      idle_q   <= idle_d;
      k7c_q    <= k7c_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    shreg_d  = window;
    bitcnt_d = bitcnt_q + 3'd1;
    bccnt_d  = bccnt_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    active_d = active_q;
    idle_d   = idle_q;
    k7c_d    = k7c_q;
    case (state_q)
      HUNT: begin
        bitcnt_d = is_bc ? 3'd0 : bitcnt_q;
        bccnt_d  = is_bc ? 4'd1 : bccnt_q;
        state_d  = !is_bc ? HUNT : (BC_COUNT == 1) ? LOCKED : COUNT;
        active_d = is_bc && (BC_COUNT == 1);
      end
      COUNT: begin
        // Lock and first byte never coincide: the locking boundary emits nothing.
        if (boundary) begin
          bccnt_d  = is_bc ? bccnt_q + 4'd1 : 4'd0;
          state_d  = !is_bc ? HUNT : (bccnt_q + 4'd1 == 4'(BC_COUNT)) ? LOCKED : COUNT;
          active_d = is_bc && (bccnt_q + 4'd1 == 4'(BC_COUNT));
        end
      end
      LOCKED: begin
        if (boundary) begin
          out_d   = window;
          valid_d = 1'b1;
          idle_d  = is_bc;
          k7c_d   = window == 8'h7C;
        end
      end
      default: state_d = HUNT;
    endcase
  end
  assign lane.out       = out_q;
  assign lane.valid_out = valid_q;
  assign lane.active    = active_q;
  assign lane.idle_k    = idle_q;
  assign lane.k7c       = k7c_q;
endmodule

// File: tb/tb_serial_a_paralelo_idle_rx.sv
// tb_serial_a_paralelo_idle_rx: random and directed lane stimulus against a bit-history reference model,
// run on a BC_COUNT=4 and a BC_COUNT=1 receiver sharing the same lane.
module tb_serial_a_paralelo_idle_rx;
  logic clk32f = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  serial_a_paralelo_idle_rx_if if0 ();
  serial_a_paralelo_idle_rx_if if1 ();
  serial_a_paralelo_idle_rx #(.BC_COUNT(4)) dut0 (.clk32f(clk32f), .reset(reset), .lane(if0.slave));
  serial_a_paralelo_idle_rx #(.BC_COUNT(1)) dut1 (.clk32f(clk32f), .reset(reset), .lane(if1.slave));
  always #5 clk32f = ~clk32f;
  assign if1.in = if0.in;
  // per-cycle expectation {active, valid, idle_k, k7c, out} and expected delivered bytes
  logic [11:0] cq0[$], cq1[$];
  logic [7:0]  bq0[$], bq1[$];
  int          bc[2] = '{4, 1};
  int          k;
  logic [7:0]  hist;
  int          anchor[2];
  int          runs[2];
  bit          locked[2];
  logic [7:0]  e_out[2];
  logic        e_valid[2], e_idle[2], e_k7c[2];
  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  // Reference: count edges since reset; an alignment anchor makes every 8th edge after it a boundary.
  task automatic model_step(input logic b, input logic rn);
    if (!rn) begin
      k = 0;
      hist = 8'h00;
      for (int i = 0; i < 2; i++) begin
        anchor[i] = -1; runs[i] = 0; locked[i] = 0;
        e_out[i] = 8'h00; e_valid[i] = 0; e_idle[i] = 0; e_k7c[i] = 0;
      end
    end else begin
      k++;
      hist = {hist[6:0], b};
      for (int i = 0; i < 2; i++) begin
        e_valid[i] = 0;
        if (locked[i]) begin
          if ((k - anchor[i]) % 8 == 0) begin
            e_out[i] = hist; e_valid[i] = 1;
            e_idle[i] = hist == 8'hBC; e_k7c[i] = hist == 8'h7C;
            if (i == 0) bq0.push_back(hist); else bq1.push_back(hist);
          end
        end else if (anchor[i] < 0) begin
          if (hist == 8'hBC) begin
            anchor[i] = k; runs[i] = 1; locked[i] = bc[i] == 1;
          end
        end else if ((k - anchor[i]) % 8 == 0) begin
          if (hist == 8'hBC) begin
            runs[i]++;
            locked[i] = runs[i] == bc[i];
          end else begin
            anchor[i] = -1; runs[i] = 0;
          end
        end
      end
    end
    cq0.push_back({locked[0], e_valid[0], e_idle[0], e_k7c[0], e_out[0]});
    cq1.push_back({locked[1], e_valid[1], e_idle[1], e_k7c[1], e_out[1]});
  endtask
  task automatic send_bit(input logic b, input logic rn);
    @(negedge clk32f);
    if0.in = b;
    reset  = rn;
    model_step(b, rn);
  endtask
  task automatic send_byte(input logic [7:0] v);
    for (int j = 7; j >= 0; j--) send_bit(v[j], 1'b1);
  endtask
  task automatic send_bcs(input int n);
    for (int j = 0; j < n; j++) send_byte(8'hBC);
  endtask
  task automatic do_reset(input int n);
    for (int j = 0; j < n; j++) send_bit(1'($urandom_range(1)), 1'b0);
  endtask
  always @(posedge clk32f) begin
    #1;
    if (cq0.size() > 0) begin
      chk("status4", {if0.active, if0.valid_out, if0.idle_k, if0.k7c, if0.out}, cq0.pop_front());
      if (if0.valid_out === 1'b1) begin
        if (bq0.size() == 0) chk("byte4_unexpected", {4'h0, if0.out}, 12'hFFF);
        else chk("byte4", {4'h0, if0.out}, {4'h0, bq0.pop_front()});
      end
    end
  end
  always @(posedge clk32f) begin
    #1;
    if (cq1.size() > 0) begin
      chk("status1", {if1.active, if1.valid_out, if1.idle_k, if1.k7c, if1.out}, cq1.pop_front());
      if (if1.valid_out === 1'b1) begin
        if (bq1.size() == 0) chk("byte1_unexpected", {4'h0, if1.out}, 12'hFFF);
        else chk("byte1", {4'h0, if1.out}, {4'h0, bq1.pop_front()});
      end
    end
  end
  initial begin
    if0.in = 1'b0;
    reset  = 1'b0;
    do_reset(10);
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
    send_bcs(6);
    do_reset(1);
    send_bcs(3); send_byte(8'h00); send_bcs(4);
    send_byte(8'h7C); send_byte(8'hA5); send_byte(8'hBC);
    // reset on the fifth bit of a byte while locked, then relock from scratch
    for (int j = 0; j < 4; j++) send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bcs(6);
    send_byte(8'h7C);
    for (int r = 0; r < 6; r++) begin
      do_reset(1 + $urandom_range(2));
      for (int j = $urandom_range(7); j > 0; j--) send_bit(1'($urandom_range(1)), 1'b1);
      if ($urandom_range(1) == 1) begin
        send_bcs(2); send_byte(8'($urandom));
      end
      send_bcs(4 + $urandom_range(2));
      for (int j = 0; j < 12; j++) begin
        case ($urandom_range(3))
          0: send_byte(8'hBC);
          1: send_byte(8'h7C);
          default: send_byte(8'($urandom));
        endcase
      end
    end
    repeat (3) @(negedge clk32f);
    chk("drain4", 12'(bq0.size() + cq0.size()), 12'd0);
    chk("drain1", 12'(bq1.size() + cq1.size()), 12'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
